// File: rtl/exmem_stage_pkg.sv
// Shared types and constants for the execute stage and EX/MEM register.
package exmem_stage_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned ALU_W  = 4;
   localparam int unsigned MEM_W  = 2;

   localparam int unsigned MEM_READ_BIT  = 0;
   localparam int unsigned MEM_WRITE_BIT = 1;

   localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_MUL = 4'b1111;

   typedef enum logic [0:0] {
      MUL_IDLE = 1'b0,
      MUL_BUSY = 1'b1
   } mul_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] store_data;
      logic [REG_W-1:0]  rd_addr;
      logic [MEM_W-1:0]  mem;
      logic              wb;
   } exmem_t;

endpackage

// File: rtl/exmem_stage_if.sv
// ID/EX-to-EX/MEM bus: operands and control in, registered results and stall out.
interface exmem_stage_if;
   import exmem_stage_pkg::*;

   logic [DATA_W-1:0] val1_i;
   logic [DATA_W-1:0] val2_i;
   logic [DATA_W-1:0] Simm_i;
   logic [ALU_W-1:0]  ALUCtrl_i;
   logic [REG_W-1:0]  rd_addr_i;
   logic [MEM_W-1:0]  Mem_i;
   logic              WB_i;
   logic [DATA_W-1:0] alu_result_o;
   logic [DATA_W-1:0] store_data_o;
   logic [REG_W-1:0]  rd_addr_o;
   logic [MEM_W-1:0]  Mem_o;
   logic              WB_o;
   logic              stall_o;
   logic              busy_o;

   modport master (
      output val1_i, val2_i, Simm_i, ALUCtrl_i, rd_addr_i, Mem_i, WB_i,
      input  alu_result_o, store_data_o, rd_addr_o, Mem_o, WB_o, stall_o, busy_o
   );

   modport slave (
      input  val1_i, val2_i, Simm_i, ALUCtrl_i, rd_addr_i, Mem_i, WB_i,
      output alu_result_o, store_data_o, rd_addr_o, Mem_o, WB_o, stall_o, busy_o
   );

endinterface

// File: rtl/exmem_stage_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per BUSY cycle.
module iter_mul
   import exmem_stage_pkg::*;
#(
   parameter int unsigned MUL_BITS = 2
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start,
   input  logic [DATA_W-1:0] mcand,
   input  logic [DATA_W-1:0] mplier,
   output logic              busy,
   output logic              last,
   output logic [DATA_W-1:0] product
);

   localparam int unsigned STEPS = DATA_W / MUL_BITS;
   localparam int unsigned CNT_W = $clog2(STEPS + 1);

   mul_state_e        state_q, state_d;
   logic [CNT_W-1:0]  count_q;
   logic [DATA_W-1:0] acc_q, mcand_q, mplier_q, pp_c;
   logic              load, step;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= MUL_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MUL_IDLE: if (start) state_d = MUL_BUSY;
         MUL_BUSY: if (count_q == CNT_W'(1)) state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      last = 1'b0;
      load = 1'b0;
      step = 1'b0;
      case (state_q)
         MUL_IDLE: load = start;
         MUL_BUSY: begin
            busy = 1'b1;
            step = 1'b1;
            last = (count_q == CNT_W'(1));
         end
         default: ;
      endcase
   end

   // Sum of the MUL_BITS partial products selected by the low multiplier bits
   always_comb begin
      pp_c = '0;
      for (int j = 0; j < int'(MUL_BITS); j++) begin
         if (mplier_q[j]) pp_c = pp_c + (mcand_q << j);
      end
   end

   assign product = acc_q + pp_c;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q  <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (load) begin
         count_q  <= CNT_W'(STEPS);
         acc_q    <= '0;
         mcand_q  <= mcand;
         mplier_q <= mplier;
      end else if (step) begin
         count_q  <= count_q - CNT_W'(1);
         acc_q    <= product;
         mcand_q  <= mcand_q << MUL_BITS;
         mplier_q <= mplier_q >> MUL_BITS;
      end
   end

endmodule

// File: rtl/exmem_stage.sv
// Execute stage plus EX/MEM register. Define EXMEM_FAST_MUL_EN for a single-cycle
// combinational MUL; otherwise MUL uses iter_mul and stalls upstream.
module exmem_stage
   import exmem_stage_pkg::*;
#(
   parameter int unsigned MUL_BITS = 2
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   exmem_stage_if.slave bus
);

   logic              is_store;
   logic              stall;
   logic              busy;
   logic [DATA_W-1:0] mul_res;
   logic [DATA_W-1:0] alu_c;
   exmem_t            exmem_q;

   assign is_store = bus.Mem_i[MEM_WRITE_BIT];

`ifdef EXMEM_FAST_MUL_EN
   assign mul_res = DATA_W'(bus.val1_i * bus.val2_i);
   assign stall   = 1'b0;
   assign busy    = 1'b0;
`else
   logic is_mul, mul_start, mul_busy, mul_last;

   assign is_mul    = (bus.ALUCtrl_i == ALU_MUL) && !is_store;
   assign mul_start = is_mul && !mul_busy;

   iter_mul #(
      .MUL_BITS (MUL_BITS)
   ) u_iter_mul (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .start   (mul_start),
      .mcand   (bus.val1_i),
      .mplier  (bus.val2_i),
      .busy    (mul_busy),
      .last    (mul_last),
      .product (mul_res)
   );

   // Stall from the start cycle until the cycle the final sum is ready
   assign stall = mul_start || (mul_busy && !mul_last);
   assign busy  = mul_busy;
`endif

   always_comb begin
      alu_c = '0;
      if (is_store) begin
         alu_c = bus.val1_i + bus.Simm_i;
      end else begin
         case (bus.ALUCtrl_i)
            ALU_ADD: alu_c = bus.val1_i + bus.val2_i;
            ALU_SUB: alu_c = bus.val1_i - bus.val2_i;
            ALU_AND: alu_c = bus.val1_i & bus.val2_i;
            ALU_OR:  alu_c = bus.val1_i | bus.val2_i;
            ALU_MUL: alu_c = mul_res;
            default: alu_c = '0;
         endcase
      end
   end

   // A stalled cycle inserts a bubble; data fields keep their previous values
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         exmem_q <= '0;
      end else if (stall) begin
         exmem_q.rd_addr <= '0;
         exmem_q.mem     <= '0;
         exmem_q.wb      <= 1'b0;
      end else begin
         exmem_q.alu_result <= alu_c;
         exmem_q.store_data <= bus.val2_i;
         exmem_q.rd_addr    <= bus.rd_addr_i;
         exmem_q.mem        <= bus.Mem_i;
         exmem_q.wb         <= bus.WB_i;
      end
   end

   assign bus.alu_result_o = exmem_q.alu_result;
   assign bus.store_data_o = exmem_q.store_data;
   assign bus.rd_addr_o    = exmem_q.rd_addr;
   assign bus.Mem_o        = exmem_q.mem;
   assign bus.WB_o         = exmem_q.wb;
   assign bus.stall_o      = stall;
   assign bus.busy_o       = busy;

endmodule

// File: tb/tb_exmem_stage.sv
// Scoreboard bench for exmem_stage: directed cases plus random instructions vs a reference model.
module tb_exmem_stage;

   localparam int unsigned MUL_BITS  = 2;
   localparam int unsigned MUL_STALL = 32 / MUL_BITS;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic [1:0]  mem;
      logic        wb;
   } exp_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   exp_t exp_q[$];

   exmem_stage_if bus ();

   exmem_stage #(
      .MUL_BITS (MUL_BITS)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] s, input logic [4:0] rd, input logic [1:0] mem,
                                  input logic wb);
      exp_t e;
      e.sd  = b;
      e.rd  = rd;
      e.mem = mem;
      e.wb  = wb;
      if (mem[1]) e.alu = a + s;
      else begin
         case (code)
            4'b0010: e.alu = a + b;
            4'b0110: e.alu = a - b;
            4'b0000: e.alu = a & b;
            4'b0001: e.alu = a | b;
            4'b1111: e.alu = a * b;
            default: e.alu = 32'd0;
         endcase
      end
      return e;
   endfunction

   task automatic drive(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s, input logic [4:0] rd, input logic [1:0] mem,
                        input logic wb);
      bus.ALUCtrl_i = code;
      bus.val1_i    = a;
      bus.val2_i    = b;
      bus.Simm_i    = s;
      bus.rd_addr_i = rd;
      bus.Mem_i     = mem;
      bus.WB_i      = wb;
   endtask

   task automatic drive_nop();
      drive(4'b0101, $urandom(), $urandom(), $urandom(), 5'd0, 2'b00, 1'b0);
   endtask

   // Called just after a rising edge; returns just after the edge that retires the instruction
   task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s, input logic [4:0] rd, input logic [1:0] mem,
                        input logic wb);
      int st, bz, cyc;
      logic last_stall;
      logic is_mul;
      is_mul = (code == 4'b1111) && !mem[1];
      drive(code, a, b, s, rd, mem, wb);
      if (wb || mem != 2'b00) exp_q.push_back(model(code, a, b, s, rd, mem, wb));
      st = 0;
      bz = 0;
      cyc = 0;
      do begin
         @(negedge clk);
         last_stall = bus.stall_o;
         if (bus.stall_o) st++;
         if (bus.busy_o) bz++;
         @(posedge clk);
         #1;
         cyc++;
      end while (last_stall && cyc < 100);
      check("stall_cycles", 80'(st), 80'(is_mul ? MUL_STALL : 0));
      check("busy_cycles", 80'(bz), 80'(is_mul ? MUL_STALL : 0));
   endtask

   // Monitor: every valid EX/MEM output must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && (bus.WB_o || bus.Mem_o != 2'b00)) begin
         exp_t act;
         act = '{bus.alu_result_o, bus.store_data_o, bus.rd_addr_o, bus.Mem_o, bus.WB_o};
         if (exp_q.size() == 0) check("unexpected_output", 80'(act), 80'(0));
         else check("exmem_out", 80'(act), 80'(exp_q.pop_front()));
      end
   end

   function automatic logic [79:0] all_outs();
      return 80'({bus.alu_result_o, bus.store_data_o, bus.rd_addr_o, bus.Mem_o, bus.WB_o,
                  bus.stall_o, bus.busy_o});
   endfunction

   initial begin
      int wb_seen;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      drive_nop();
      #12;
      check("reset_state", all_outs(), 80'(0));
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(4'b0010, 32'd5, 32'd7, 32'd0, 5'd3, 2'b00, 1'b1);
      issue(4'b0110, 32'd3, 32'd5, 32'd0, 5'd4, 2'b00, 1'b1);
      issue(4'b0000, 32'hF0F0, 32'hFF00, 32'd0, 5'd5, 2'b00, 1'b1);
      issue(4'b0001, 32'hF0F0, 32'hFF00, 32'd0, 5'd6, 2'b00, 1'b1);
      issue(4'b0101, 32'h1234, 32'h5678, 32'd0, 5'd7, 2'b00, 1'b1);
      issue(4'b1111, 32'hFFFFFFFF, 32'd3, 32'd0, 5'd8, 2'b00, 1'b1);
      issue(4'b0010, 32'd1, 32'd1, 32'd0, 5'd9, 2'b00, 1'b1);
      issue(4'b1111, 32'd7, 32'd6, 32'd0, 5'd10, 2'b00, 1'b1);
      issue(4'b1111, 32'd9, 32'd9, 32'd0, 5'd11, 2'b00, 1'b1);
      issue(4'b1111, 32'h100, 32'hCD, 32'h10, 5'd0, 2'b10, 1'b0);
      issue(4'b0010, 32'h100, 32'hAB, 32'hFFFFFFFC, 5'd0, 2'b10, 1'b0);

      // Asynchronous reset while the store result is on the outputs
      drive_nop();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("async_reset_outputs", all_outs(), 80'(0));
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(4'b0010, 32'd5, 32'd7, 32'd0, 5'd3, 2'b00, 1'b1);

      // Reset during the 8th BUSY cycle aborts the multiply with no writeback
      drive(4'b1111, 32'h12345, 32'h777, 32'd0, 5'd12, 2'b00, 1'b1);
      repeat (8) @(posedge clk);
      #1 check("busy_before_abort", 80'({bus.busy_o, bus.stall_o}), 80'(2'b11));
      rst_n = 1'b0;
      drive_nop();
      #1 check("abort_stall_busy", 80'({bus.stall_o, bus.busy_o}), 80'(0));
      #2 rst_n = 1'b1;
      wb_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.WB_o || bus.stall_o || bus.busy_o) wb_seen++;
      end
      check("no_wb_after_abort", 80'(wb_seen), 80'(0));
      @(posedge clk);
      #1;

      for (int n = 0; n < 300; n++) begin
         logic [3:0]  code;
         logic [1:0]  mem;
         logic        wb;
         logic [31:0] a, b;
         case ($urandom_range(0, 7))
            0:       code = 4'b0010;
            1:       code = 4'b0110;
            2:       code = 4'b0000;
            3:       code = 4'b0001;
            4:       code = 4'b1111;
            default: code = 4'($urandom_range(0, 15));
         endcase
         case ($urandom_range(0, 2))
            0:       begin mem = 2'b00; wb = 1'b1; end
            1:       begin mem = 2'b01; wb = 1'b1; end
            default: begin mem = 2'b10; wb = 1'b0; end
         endcase
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
         issue(code, a, b, $urandom(), 5'($urandom_range(0, 31)), mem, wb);
      end

      drive_nop();
      repeat (3) @(posedge clk);
      #1 check("queue_drained", 80'(exp_q.size()), 80'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
